// File: rtl/peripheral_ahb_pkg.sv
// peripheral_ahb_pkg: AHB-Lite encodings and initiator FSM states
package peripheral_ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;
endpackage

// File: rtl/peripheral_spram_initiator.sv
// peripheral_spram_initiator: turns single commands into one AHB-Lite SINGLE transfer
// each, with no address/data overlap, and returns one response per command.
module peripheral_spram_initiator
   import peripheral_ahb_pkg::*;
#(
   parameter int          PLEN        = 8,
   parameter int          XLEN        = 32,
   parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
   input  logic            HRESETn,
   input  logic            HCLK,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [PLEN-1:0] cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,
   input  logic [2:0]      cmd_size,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_error,
   output logic            HSEL,
   output logic [PLEN-1:0] HADDR,
   output logic [XLEN-1:0] HWDATA,
   input  logic [XLEN-1:0] HRDATA,
   output logic            HWRITE,
   output logic [2:0]      HSIZE,
   output logic [2:0]      HBURST,
   output logic [3:0]      HPROT,
   output logic [1:0]      HTRANS,
   output logic            HMASTLOCK,
   input  logic            HREADY,
   input  logic            HRESP
);
   localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN / 8));
   state_e            state_q, state_d;
   logic              write_q;
   logic [PLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q, rdata_q;
   logic [2:0]        size_q;
   logic              error_q;
   logic              accept, legal;
   logic [PLEN-1:0]   align_mask;
   // Oversized or misaligned commands are answered locally without touching the bus
   assign align_mask = PLEN'((32'd1 << cmd_size) - 32'd1);
   assign legal      = (cmd_size <= MAX_SIZE) && ((cmd_addr & align_mask) == '0);
   assign accept     = cmd_valid && cmd_ready;
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = cmd_valid ? (legal ? ST_ADDR : ST_RESP) : ST_IDLE;
         ST_ADDR: state_d = HREADY ? ST_DATA : ST_ADDR;
         ST_DATA: state_d = HREADY ? ST_RESP : ST_DATA;
         ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      cmd_ready = state_q == ST_IDLE;
      rsp_valid = state_q == ST_RESP;
      HSEL      = state_q == ST_ADDR;
      HTRANS    = HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;
      HADDR     = HSEL ? addr_q : '0;
      HWRITE    = HSEL && write_q;
      HSIZE     = HSEL ? size_q : HSIZE_BYTE;
      HWDATA    = (state_q == ST_DATA && write_q) ? wdata_q : '0;
   end
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VALUE;
   assign HMASTLOCK = 1'b0;
   assign rsp_rdata = rdata_q;
   assign rsp_error = error_q;
   // The error status is taken only on the completing (HREADY=1) data cycle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else if (accept) begin
         write_q <= cmd_write;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         size_q  <= cmd_size;
         rdata_q <= '0;
         error_q <= !legal;
      end else if (state_q == ST_DATA && HREADY) begin
         rdata_q <= write_q ? '0 : HRDATA;
         error_q <= HRESP == HRESP_ERROR;
      end
   end
endmodule

// File: tb/tb_peripheral_spram_initiator.sv
// tb_peripheral_spram_initiator: directed and random commands against a byte-level
// memory model, with a waited/erroring AHB responder built into the bench.
module tb_peripheral_spram_initiator;
   logic        HRESETn, HCLK;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [31:0] rsp_rdata;
   logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [7:0]  HADDR;
   logic [31:0] HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   int tests = 0, fails = 0;
   peripheral_spram_initiator dut (
      .HRESETn(HRESETn), .HCLK(HCLK),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
      .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
   );
   initial HCLK = 0;
   always #5 HCLK = ~HCLK;
   // Responder: data phase lasts wait_n extra cycles; error mode gives the two-cycle ERROR
   bit [31:0] bus_mem [64];
   bit        dp_active, dp_write, dp_err;
   int        dp_cnt;
   logic [7:0] dp_addr;
   logic [2:0] dp_size;
   int        wait_n = 0;
   bit        err_mode = 0;
   int        nonseq_cnt = 0;
   assign HREADY = !dp_active || dp_cnt == 0;
   assign HRESP  = dp_active && dp_err && dp_cnt <= 1;
   assign HRDATA = (dp_active && !dp_write && !dp_err) ? bus_mem[dp_addr[7:2]] : 32'h0;
   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_active <= 0;
         dp_cnt    <= 0;
      end else begin
         if (dp_active && HREADY) begin
            if (dp_write && !dp_err)
               for (int b = 0; b < 4; b++)
                  if (b >= int'(dp_addr[1:0]) && b < int'(dp_addr[1:0]) + (1 << dp_size))
                     bus_mem[dp_addr[7:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            dp_active <= 0;
         end else if (dp_active) dp_cnt <= dp_cnt - 1;
         if (HREADY && HSEL && HTRANS == 2'b10) begin
            nonseq_cnt <= nonseq_cnt + 1;
            dp_active  <= 1;
            dp_addr    <= HADDR;
            dp_write   <= HWRITE;
            dp_size    <= HSIZE;
            dp_err     <= err_mode;
            dp_cnt     <= (err_mode && wait_n < 1) ? 1 : wait_n;
         end
      end
   end
   bit [7:0] ref_mem [256];
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
      chk({tag, "_rsp_error"}, rsp_error, 0);
      chk({tag, "_htrans"}, HTRANS, 0);
      chk({tag, "_hsel"}, HSEL, 0);
      chk({tag, "_haddr"}, HADDR, 0);
      chk({tag, "_hwdata"}, HWDATA, 0);
      chk({tag, "_hwrite"}, HWRITE, 0);
      chk({tag, "_hsize"}, HSIZE, 0);
      chk({tag, "_hburst"}, HBURST, 0);
      chk({tag, "_hprot"}, HPROT, 4'b0011);
      chk({tag, "_hmastlock"}, HMASTLOCK, 0);
   endtask
   task automatic do_cmd(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [2:0] s,
                         input int waits, input bit err, input int rdelay);
      bit legal, exp_err;
      int exp_lat, c, n0, base;
      logic [31:0] exp_rd, rd0;
      logic er0;
      legal = (s <= 2) && (int'(a) % (1 << s) == 0);
      base  = int'(a) & ~3;
      exp_rd = 0;
      if (!legal) begin
         exp_err = 1;
         exp_lat = 1;
      end else begin
         exp_err = err;
         exp_lat = 3 + ((err && waits < 1) ? 1 : waits);
         if (!w && !err) exp_rd = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
         if (w && !err)
            for (int b = 0; b < 4; b++)
               if (b >= int'(a[1:0]) && b < int'(a[1:0]) + (1 << s)) ref_mem[base+b] = d[8*b +: 8];
      end
      chk("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = s;
      wait_n = waits; err_mode = err; n0 = nonseq_cnt;
      @(posedge HCLK); #1;
      cmd_valid = 0;
      c = 1;
      if (legal) begin
         chk("addr_htrans", HTRANS, 2'b10);
         chk("addr_hsel", HSEL, 1);
         chk("addr_haddr", HADDR, a);
         chk("addr_hwrite", HWRITE, w);
         chk("addr_hsize", HSIZE, s);
         chk("addr_hburst_hprot_lock", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
         @(posedge HCLK); #1;
         c = 2;
         chk("data_htrans", HTRANS, 0);
         chk("data_hwdata", HWDATA, w ? d : 32'h0);
      end
      while (!rsp_valid && c < 40) begin
         @(posedge HCLK); #1;
         c++;
      end
      chk("rsp_latency", c, exp_lat);
      chk("rsp_error", rsp_error, exp_err);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      rd0 = rsp_rdata; er0 = rsp_error;
      repeat (rdelay) begin
         @(posedge HCLK); #1;
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_data", {rsp_error, rsp_rdata}, {er0, rd0});
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1;
      @(posedge HCLK); #1;
      rsp_ready = 0;
      chk("single_response", rsp_valid, 0);
      chk("nonseq_count", nonseq_cnt - n0, legal ? 1 : 0);
   endtask
   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      HRESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_size = 0;
      rsp_ready = 0;
      #1;
      chk_reset_outputs("reset");
      @(posedge HCLK); #1;
      HRESETn = 1;
      do_cmd(1, 8'h10, 32'hDEADBEEF, 3'd2, 0, 0, 0);
      do_cmd(0, 8'h10, 32'h0, 3'd2, 2, 0, 0);
      do_cmd(0, 8'h10, 32'h0, 3'd2, 0, 1, 0);
      do_cmd(1, 8'h14, 32'h12345678, 3'd2, 1, 1, 0);
      do_cmd(1, 8'h11, 32'hCAFEF00D, 3'd2, 0, 0, 0);
      do_cmd(0, 8'h14, 32'h0, 3'd2, 0, 0, 0);
      do_cmd(1, 8'h18, 32'hA5A5A5A5, 3'd2, 1, 0, 4);
      rsp_ready = 1;
      @(posedge HCLK); #1;
      chk("stray_rsp_ready_idle", cmd_ready, 1);
      rsp_ready = 0;
      // Reset during a waited read data phase
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h18; cmd_size = 3'd2; wait_n = 3; err_mode = 0;
      @(posedge HCLK); #1;
      cmd_valid = 0;
      @(posedge HCLK); #1;
      chk("pre_reset_in_data", {HTRANS, HREADY}, {2'b00, 1'b0});
      HRESETn = 0;
      #1;
      chk_reset_outputs("midreset");
      @(posedge HCLK); #1;
      HRESETn = 1;
      do_cmd(0, 8'h18, 32'h0, 3'd2, 0, 0, 0);
      for (int i = 0; i < 40; i++)
         do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 2));
      for (int i = 0; i < 8; i++)
         do_cmd(0, 8'(4 * i), 32'h0, 3'd2, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
